mul_seq_dispatch: RTL and testbench
===================================

Name: mul_seq_dispatch

Overview:
Front-end/back-end shell for the sequential multiplier (mul_seq). It queues operand pairs from a valid/ready source, issues them one at a time on the multiplier's START/A/B pulse interface, and waits for DONE. It captures Y into a result register with a valid/ready sink, and flags jobs whose DONE never arrives. It sits between the operand producer and the result consumer, and directly wraps one multiplier instance's ports.

Parameters:
LEN, 16, operand/result width (matches multiplier LEN)
DEPTH, 4, operand FIFO entries; power of two, >=2
TIMEOUT, 20, max cycles from issue to DONE before a job is declared failed; >= multiplier worst-case latency + 2

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  synchronous reset, active-low
IN_VALID  in  1  operand pair offered
IN_READY  out  1  FIFO can accept (= !full)
IN_A  in  LEN  operand A
IN_B  in  LEN  operand B
OUT_VALID  out  1  result register holds an unread result
OUT_READY  in  1  sink takes result
OUT_Y  out  LEN  product (low LEN bits), 0 on error
OUT_ERR  out  1  result is a timeout, qualified by OUT_VALID
MUL_START  out  1  one-cycle start pulse to multiplier
MUL_A  out  LEN  operand A to multiplier
MUL_B  out  LEN  operand B to multiplier
MUL_DONE  in  1  multiplier done level
MUL_Y  in  LEN  multiplier result, valid while MUL_DONE
BUSY  out  1  state!=IDLE or FIFO non-empty or OUT_VALID

Behaviour:
- Reset (RST_N=0 at edge): FIFO emptied, state IDLE, timeout counter 0. OUT_VALID=0, OUT_ERR=0, OUT_Y=0, MUL_START=0, MUL_A=0, MUL_B=0. An in-flight job is discarded; any MUL_DONE later seen in IDLE is ignored.
- All outputs registered except IN_READY and BUSY (combinational from registered state/count).
- FIFO: push on IN_VALID&&IN_READY. Pop only on IDLE->ISSUE. Push and pop in the same cycle is allowed when not full; count unchanged. When full, IN_READY=0 even if a pop occurs that cycle. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO non-empty -> ISSUE. Pop head into MUL_A/MUL_B and set MUL_START=1.
  - ISSUE (MUL_START=1 for exactly this cycle): -> BLANK, MUL_START=0, counter=1.
  - BLANK: one cycle; MUL_DONE ignored, since it may still show the previous job's stale DONE. -> WAIT, counter+1.
  - WAIT: counter+1 each cycle.
    - If MUL_DONE=1 and slot free (!OUT_VALID or OUT_READY): OUT_Y<=MUL_Y, OUT_ERR<=0, OUT_VALID<=1, -> IDLE.
    - Else if counter>=TIMEOUT and slot free: OUT_Y<=0, OUT_ERR<=1, OUT_VALID<=1, -> IDLE.
    - If the slot is not free, stay in WAIT. The counter saturates at TIMEOUT. A DONE that arrives after the timeout but before the slot frees is still captured as a good result (DONE has priority).
- MUL_A/MUL_B hold their values from issue until the next issue.
- Result slot: OUT_VALID cleared on OUT_READY unless reloaded the same cycle. A load and a drain in the same cycle leaves OUT_VALID=1 with the new data. OUT_Y/OUT_ERR are stable while OUT_VALID&&!OUT_READY.
- Overlap: a new job may be issued while OUT_VALID=1 (awaiting drain).
- Latency, empty FIFO, slot free, multiplier raises DONE D cycles after the START edge (D>=2):
  - handshake at edge E0
  - MUL_START high in the cycle after E1
  - capture at the first WAIT edge with DONE
  - OUT_VALID high after that edge
  - minimum accept-to-OUT_VALID = 4 cycles
- Arithmetic: no width growth; OUT_Y = MUL_Y truncated to LEN. Product correctness is the multiplier's responsibility.

Test Plan:
- Single job, LEN=16, real multiplier: A=3, B=5, OUT_READY=1 -> one MUL_START pulse; OUT_VALID with OUT_Y=0x000F, OUT_ERR=0. BUSY returns 0 the cycle after the drain.
- Wrap-around product: A=0xFFFF, B=0xFFFF -> OUT_Y=0x0001. Then i*193 and i*1543 for i=0..99 -> each OUT_Y equals the truncated product, in order.
- FIFO full: OUT_READY=0, push 5 pairs back-to-back, DEPTH=4 -> 1 issued, then 4 queued, IN_READY=0 on the 6th offer. Release OUT_READY -> all results emerge in order, none lost or duplicated.
- Backpressure: hold OUT_READY=0 while job 2 completes -> job 2 stays in WAIT, OUT_Y keeps job 1's value. One OUT_READY cycle -> job 1 drained and job 2 loaded on the same edge.
- Timeout: stub multiplier never asserts MUL_DONE, TIMEOUT=20 -> OUT_VALID with OUT_ERR=1, OUT_Y=0, 20 cycles after the ISSUE edge. The next queued job then issues normally.
- Reset mid-WAIT: RST_N=0 for 1 cycle with 2 jobs queued -> all outputs 0, IN_READY=1, BUSY=0. A stale MUL_DONE after reset produces no OUT_VALID.

Source files
------------

// File: rtl/mul_seq_dispatch.sv
// mul_seq_dispatch: queues operand pairs and issues them one at a time to a
// sequential multiplier over its START/A/B pulse interface. It then waits for
// DONE and captures the product into a single valid/ready result slot. A job
// whose DONE never arrives within TIMEOUT cycles is reported as an error result.
module mul_seq_dispatch #(
    parameter int LEN     = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 20
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [LEN-1:0] IN_A,
    input  logic [LEN-1:0] IN_B,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [LEN-1:0] OUT_Y,
    output logic           OUT_ERR,
    output logic           MUL_START,
    output logic [LEN-1:0] MUL_A,
    output logic [LEN-1:0] MUL_B,
    input  logic           MUL_DONE,
    input  logic [LEN-1:0] MUL_Y,
    output logic           BUSY
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BLANK = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Operand queue
    logic [LEN-1:0]   fifo_a_r [DEPTH];
    logic [LEN-1:0]   fifo_b_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Issue/wait sequencing
    state_t           state_r;
    logic [TMR_W-1:0] timer_r;
    logic             mul_start_r;
    logic [LEN-1:0]   mul_a_r;
    logic [LEN-1:0]   mul_b_r;

    // Result slot
    logic             out_valid_r;
    logic [LEN-1:0]   out_y_r;
    logic             out_err_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             slot_free_s;
    logic             timed_out_s;
    logic             load_good_s;
    logic             load_err_s;
    logic [TMR_W-1:0] timer_inc_s;

    // Handshake decode, slot availability and saturating timer increment
    always_comb begin
        full_s      = (count_r == CNT_W'(DEPTH));
        empty_s     = (count_r == CNT_W'(0));
        push_s      = IN_VALID && !full_s;
        pop_s       = (state_r == ST_IDLE) && !empty_s;
        slot_free_s = !out_valid_r || OUT_READY;
        timed_out_s = (timer_r >= TMR_W'(TIMEOUT));
        // DONE wins over the timeout even after the counter has saturated
        load_good_s = (state_r == ST_WAIT) && MUL_DONE && slot_free_s;
        load_err_s  = (state_r == ST_WAIT) && !MUL_DONE && timed_out_s && slot_free_s;
        if (timed_out_s) begin
            timer_inc_s = timer_r;
        end else begin
            timer_inc_s = timer_r + TMR_W'(1);
        end
    end

    // Queue storage: written on accept only, contents need no reset
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_a_r[wr_ptr_r] <= IN_A;
            fifo_b_r[wr_ptr_r] <= IN_B;
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Job sequencer: issue pulse, one blanking cycle for stale DONE, then wait
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            timer_r     <= TMR_W'(0);
            mul_start_r <= 1'b0;
            mul_a_r     <= {LEN{1'b0}};
            mul_b_r     <= {LEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mul_start_r <= 1'b0;
                    if (!empty_s) begin
                        mul_a_r     <= fifo_a_r[rd_ptr_r];
                        mul_b_r     <= fifo_b_r[rd_ptr_r];
                        mul_start_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_start_r <= 1'b0;
                    timer_r     <= TMR_W'(1);
                    state_r     <= ST_BLANK;
                end
                ST_BLANK: begin
                    timer_r <= timer_inc_s;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer_r <= timer_inc_s;
                    if (load_good_s || load_err_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mul_start_r <= 1'b0;
                    timer_r     <= TMR_W'(0);
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Result slot: a load on the same edge as a drain keeps OUT_VALID high
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid_r <= 1'b0;
            out_y_r     <= {LEN{1'b0}};
            out_err_r   <= 1'b0;
        end else if (load_good_s) begin
            out_valid_r <= 1'b1;
            out_y_r     <= MUL_Y;
            out_err_r   <= 1'b0;
        end else if (load_err_s) begin
            out_valid_r <= 1'b1;
            out_y_r     <= {LEN{1'b0}};
            out_err_r   <= 1'b1;
        end else if (OUT_READY) begin
            out_valid_r <= 1'b0;
        end
    end

    assign IN_READY  = !full_s;
    assign OUT_VALID = out_valid_r;
    assign OUT_Y     = out_y_r;
    assign OUT_ERR   = out_err_r;
    assign MUL_START = mul_start_r;
    assign MUL_A     = mul_a_r;
    assign MUL_B     = mul_b_r;
    assign BUSY      = (state_r != ST_IDLE) || !empty_s || out_valid_r;

endmodule

// File: tb/tb_mul_seq_dispatch.sv
// Directed bench for mul_seq_dispatch with a behavioural multiplier model
// (programmable latency, optional stuck-DONE stub) and an in-order scoreboard.
module tb_mul_seq_dispatch;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] IN_A = 16'h0000;
    logic [15:0] IN_B = 16'h0000;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_Y;
    logic        OUT_ERR;
    logic        MUL_START;
    logic [15:0] MUL_A;
    logic [15:0] MUL_B;
    wire         MUL_DONE;
    wire  [15:0] MUL_Y;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_y [$];
    logic        exp_e [$];

    // Multiplier model state
    int          mul_lat    = 2;
    logic        mul_stub   = 1'b0;
    logic        mul_done_r = 1'b0;
    logic [15:0] mul_y_r    = 16'h0000;
    logic [15:0] m_a        = 16'h0000;
    logic [15:0] m_b        = 16'h0000;
    int          m_cnt      = 0;
    int          start_cnt  = 0;

    mul_seq_dispatch #(.LEN(16), .DEPTH(4), .TIMEOUT(20)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_Y     (OUT_Y),
        .OUT_ERR   (OUT_ERR),
        .MUL_START (MUL_START),
        .MUL_A     (MUL_A),
        .MUL_B     (MUL_B),
        .MUL_DONE  (MUL_DONE),
        .MUL_Y     (MUL_Y),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    assign MUL_DONE = mul_done_r && !mul_stub;
    assign MUL_Y    = mul_y_r;

    // Multiplier model: DONE level rises mul_lat cycles after the START edge
    always @(posedge CLK) begin
        if (MUL_START) begin
            m_a        <= MUL_A;
            m_b        <= MUL_B;
            m_cnt      <= mul_lat - 1;
            mul_done_r <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_done_r <= 1'b1;
                mul_y_r    <= 16'(m_a * m_b);
            end
        end
    end

    // Count issued start pulses
    always @(negedge CLK) begin
        if (MUL_START) begin
            start_cnt <= start_cnt + 1;
        end
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer one pair; called at a negedge, returns at the negedge after the accept edge
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int w = 0;
        IN_VALID = 1'b1;
        IN_A     = a;
        IN_B     = b;
        while (!IN_READY && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (!IN_READY) chk("push_wait", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] y, input logic e);
        exp_y.push_back(y);
        exp_e.push_back(e);
        push(a, b);
    endtask

    // Check n results in order; samples each negedge where a transfer will happen
    task automatic collect(input int n);
        int got = 0;
        int w   = 0;
        while (got < n && w < 3000) begin
            if (OUT_VALID && OUT_READY) begin
                if (exp_y.size() == 0) begin
                    chk("extra_result", 32'(OUT_Y), 32'hFFFF_FFFF);
                end else begin
                    chk("res_y", 32'(OUT_Y), 32'(exp_y.pop_front()));
                    chk("res_err", 32'(OUT_ERR), 32'(exp_e.pop_front()));
                end
                got++;
            end
            @(negedge CLK);
            w++;
        end
        if (got < n) chk("collect_count", 32'(got), 32'(n));
    endtask

    initial begin
        int n;
        int s0;
        int seen;

        // Reset state
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out_err", 32'(OUT_ERR), 32'd0);
        chk("rst_out_y", 32'(OUT_Y), 32'd0);
        chk("rst_mul_start", 32'(MUL_START), 32'd0);
        chk("rst_mul_a", 32'(MUL_A), 32'd0);
        chk("rst_mul_b", 32'(MUL_B), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single job 3*5, minimum latency
        OUT_READY = 1'b1;
        mul_lat   = 2;
        s0        = start_cnt;
        push(16'd3, 16'd5);
        n = 0;
        while (!OUT_VALID && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("single_latency", 32'(n), 32'd4);
        chk("single_y", 32'(OUT_Y), 32'h0000_000F);
        chk("single_err", 32'(OUT_ERR), 32'd0);
        @(negedge CLK);
        chk("single_busy_after_drain", 32'(BUSY), 32'd0);
        chk("single_out_valid_after_drain", 32'(OUT_VALID), 32'd0);
        chk("single_start_pulses", 32'(start_cnt - s0), 32'd1);
        chk("single_mul_a_hold", 32'(MUL_A), 32'd3);
        chk("single_mul_b_hold", 32'(MUL_B), 32'd5);

        // Wrap-around product
        push_exp(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
        collect(1);

        // Streamed truncated products, producer and consumer concurrent
        mul_lat = 3;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    push_exp(16'(i * 193), 16'(i * 1543), 16'(i * 193 * i * 1543), 1'b0);
                end
            end
            collect(100);
        join

        // FIFO full with sink stalled, then backpressure and single-cycle drain
        OUT_READY = 1'b0;
        mul_lat   = 2;
        push_exp(16'd2, 16'd3, 16'd6, 1'b0);
        push_exp(16'd4, 16'd5, 16'd20, 1'b0);
        push_exp(16'd6, 16'd7, 16'd42, 1'b0);
        push_exp(16'd8, 16'd9, 16'd72, 1'b0);
        push_exp(16'd10, 16'd11, 16'd110, 1'b0);
        chk("full_in_ready", 32'(IN_READY), 32'd0);
        repeat (12) @(negedge CLK);
        chk("bp_hold_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_hold_y", 32'(OUT_Y), 32'd6);
        chk("bp_busy", 32'(BUSY), 32'd1);
        OUT_READY = 1'b1;
        chk("bp_drain1_y", 32'(OUT_Y), 32'(exp_y.pop_front()));
        chk("bp_drain1_err", 32'(OUT_ERR), 32'(exp_e.pop_front()));
        @(negedge CLK);
        OUT_READY = 1'b0;
        chk("bp_load2_valid", 32'(OUT_VALID), 32'd1);
        chk("bp_load2_y", 32'(OUT_Y), 32'd20);
        repeat (3) @(negedge CLK);
        chk("bp_load2_stable", 32'(OUT_Y), 32'd20);
        OUT_READY = 1'b1;
        collect(4);
        chk("full_no_extra", 32'(OUT_VALID), 32'd0);
        chk("full_queue_empty", 32'(exp_y.size()), 32'd0);

        // Timeout with stuck multiplier, then a normal job behind it
        mul_stub = 1'b1;
        push_exp(16'd7, 16'd9, 16'd0, 1'b1);
        push_exp(16'd6, 16'd6, 16'd36, 1'b0);
        chk("to_start_seen", 32'(MUL_START), 32'd1);
        n = 0;
        while (!OUT_VALID && n < 100) begin
            @(negedge CLK);
            n++;
        end
        // 21 edges after the edge raising MUL_START = 20 after leaving ISSUE
        chk("to_cycles", 32'(n), 32'd21);
        mul_stub = 1'b0;
        collect(2);

        // Reset while waiting with jobs queued; stale DONE must be ignored
        mul_lat = 8;
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("mr_out_valid", 32'(OUT_VALID), 32'd0);
        chk("mr_out_y", 32'(OUT_Y), 32'd0);
        chk("mr_out_err", 32'(OUT_ERR), 32'd0);
        chk("mr_mul_start", 32'(MUL_START), 32'd0);
        chk("mr_mul_a", 32'(MUL_A), 32'd0);
        chk("mr_mul_b", 32'(MUL_B), 32'd0);
        chk("mr_in_ready", 32'(IN_READY), 32'd1);
        chk("mr_busy", 32'(BUSY), 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (OUT_VALID || MUL_START) seen++;
        end
        chk("mr_stale_done_ignored", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
